operand_loader: RTL
===================

// Module: operand_loader
// PURPOSE
//  Upstream front-end for the GCD/LCM processor. Takes one 8-bit switch bank and one push-button.
//  Successive presses latch X, latch Y, then fire a one-cycle start (with op) into the processor.
//  Waits for done, captures the result and holds it for display until the next press restarts the cycle.
//  A missing done within a bounded time raises an error flag instead of hanging.
// PARAMETERS
//  DB_CYCLES   50000  stable-input cycles a button level needs before it is accepted (DEBOUNCE_EN only)
//  DB_W        16     width of the debounce counter; must hold DB_CYCLES
//  WAIT_MAX    1023   max cycles from start to done before timeout
//  WAIT_W      10     width of the timeout counter; must hold WAIT_MAX
// PORTS
//  clk         in   1  system clock
//  rst         in   1  asynchronous, active-high reset
//  btn         in   1  raw push-button, asynchronous, active-high
//  sw          in   8  raw operand switches
//  op_sw       in   1  raw operation-select switch
//  done        in   1  processor done level
//  proc_result in   8  processor result
//  x           out  8  latched X operand to the processor
//  y           out  8  latched Y operand to the processor
//  op          out  1  op latched at start, held stable while running
//  start       out  1  one-cycle start pulse
//  result      out  8  captured result, held
//  err         out  1  timeout flag, held until next press
//  phase       out  3  one-hot-free state code for LEDs: 0=X 1=Y 2=GO 3=RUN 4=SHOW
// BEHAVIOUR
//  - Reset (async assert, sync release): state=S_X; x=y=result=0; op=start=err=0; counters=0.
//  - btn and op_sw pass through a 2-flop synchroniser. press = rising edge of the conditioned btn:
//    one cycle high, 3 cycles after a clean edge on btn without DEBOUNCE_EN.
//  - S_X: on press, x<=sw (sampled in the press cycle), go to S_Y.
//  - S_Y: on press, y<=sw, go to S_GO.
//  - S_GO: on press, op<=synchronised op_sw, start=1 for exactly that next cycle, go to S_RUN.
//    Clear wait counter and err.
//  - S_RUN: the first cycle after start ignores done. This masks a stale done from the previous run.
//    - From the 2nd cycle on, done=1: result<=proc_result, go to S_SHOW.
//    - Otherwise the wait counter increments. When it reaches WAIT_MAX: err<=1, result<=8'hFF, go to S_SHOW.
//    - Presses in S_RUN are dropped; they are not queued.
//  - S_SHOW: result/err held. On press, clear err and go to S_X. x/y/op keep their old values until overwritten.
//  - Simultaneous done and timeout in the same cycle: done wins, err stays 0.
//  - A press and an internal transition never coincide except in the listed press transitions.
//  - Async reset mid-run: start deasserts immediately; the next run begins from S_X.
//  - Counters saturate; they never wrap.
// CONFIGURATION
//  OPERAND_LOADER_DEBOUNCE_EN
//    defined: the synchronised btn must hold a new level for DB_CYCLES consecutive cycles before the
//      conditioned level changes. Press latency is DB_CYCLES+3 cycles after a clean edge. Bounces shorter
//      than DB_CYCLES produce no press.
//    undefined: the conditioned level = synchronised btn. DB_CYCLES and DB_W are unused.
// STRUCTURE
//  - proc_pkg: state enum, phase codes, RESULT_TIMEOUT = 8'hFF.
//  - Sub-module btn_conditioner: synchroniser, optional debounce counter and rising-edge detect; outputs press.
//  - operand_loader holds the FSM, operand/result registers and timeout counter.
// TESTING
//  1 Reset: assert rst mid-S_RUN -> start=0, state S_X, x=y=result=0 the same cycle.
//  2 Load/run: sw=8'd12 press, sw=8'd18 press, op_sw=0 press -> x=12, y=18, one start pulse.
//    Then done=1 with proc_result=6 two cycles later -> result=6, phase=4.
//  3 Stale done: done held 1 across start -> not accepted in the first RUN cycle; accepted in the second.
//  4 Timeout: done never rises -> after WAIT_MAX+1 RUN cycles err=1, result=8'hFF. Next press clears err, phase=0.
//  5 Debounce (macro on, DB_CYCLES=8): 5-cycle glitches on btn -> no press. Clean 20-cycle hold -> exactly one press.
//  6 Press during S_RUN: ignored; x/y unchanged, no second start pulse.

Source files
------------

// File: rtl/operand_loader_pkg.sv
// Shared types for the GCD/LCM operand loader: FSM states, LED phase codes, timeout marker.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package operand_loader_pkg;

   localparam logic [2:0] PH_X    = 3'd0;
   localparam logic [2:0] PH_Y    = 3'd1;
   localparam logic [2:0] PH_GO   = 3'd2;
   localparam logic [2:0] PH_RUN  = 3'd3;
   localparam logic [2:0] PH_SHOW = 3'd4;

   localparam logic [7:0] RESULT_TIMEOUT = 8'hFF;

   // State encoding doubles as the LED phase code.
   typedef enum logic [2:0] {
      S_X    = PH_X,
      S_Y    = PH_Y,
      S_GO   = PH_GO,
      S_RUN  = PH_RUN,
      S_SHOW = PH_SHOW
   } state_t;

   function automatic logic [2:0] phase_of(state_t s);
      return 3'(s);
   endfunction

endpackage

// File: rtl/operand_loader_if.sv
// Loader-to-processor link: operands, op and start out; done level and result back.
// Latency: combinational wires only.
// Backpressure: none; start is a single-cycle pulse, done is a held level.
interface operand_loader_if;
   logic [7:0] x;
   logic [7:0] y;
   logic       op;
   logic       start;
   logic       done;
   logic [7:0] proc_result;

   modport master (output x, output y, output op, output start,
                   input done, input proc_result);
   modport slave  (input x, input y, input op, input start,
                   output done, output proc_result);
endinterface

// File: rtl/operand_loader_btn_conditioner.sv
// Push-button conditioner: 2-flop synchroniser, optional debounce (OPERAND_LOADER_DEBOUNCE_EN), rising-edge pulse.
// Latency: press 3 cycles after a clean edge, DB_CYCLES+3 with debounce enabled.
// Backpressure: none; press is a one-cycle pulse that is consumed or lost.
module operand_loader_btn_conditioner
`ifdef OPERAND_LOADER_DEBOUNCE_EN
#(
   parameter int unsigned DB_CYCLES = 50000,
   parameter int unsigned DB_W      = 16
)
`endif
(
   input  logic clk,
   input  logic rst,
   input  logic btn,
   output logic press
);

   logic [1:0] sync_q;
   logic       level;
   logic       level_d;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) sync_q <= 2'b00;
      else     sync_q <= {sync_q[0], btn};
   end

`ifdef OPERAND_LOADER_DEBOUNCE_EN
   logic [DB_W-1:0] db_cnt;

   // Level flips only after the new value has been seen DB_CYCLES times in a row.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         level  <= 1'b0;
         db_cnt <= '0;
      end else if (sync_q[1] == level) begin
         db_cnt <= '0;
      end else if (db_cnt == DB_W'(DB_CYCLES - 1)) begin
         level  <= sync_q[1];
         db_cnt <= '0;
      end else begin
         db_cnt <= db_cnt + 1'b1;
      end
   end
`else
   assign level = sync_q[1];
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         level_d <= 1'b0;
         press   <= 1'b0;
      end else begin
         level_d <= level;
         press   <= level & ~level_d;
      end
   end

endmodule

// File: rtl/operand_loader.sv
// GCD/LCM front-end: presses latch X, latch Y, fire start; captures result or flags timeout (OPERAND_LOADER_DEBOUNCE_EN).
// Latency: start one cycle after the GO press; result captured the cycle done is accepted.
// Backpressure: presses outside X/Y/GO/SHOW are dropped, not queued.
module operand_loader
   import operand_loader_pkg::*;
#(
`ifdef OPERAND_LOADER_DEBOUNCE_EN
   parameter int unsigned DB_CYCLES = 50000,
   parameter int unsigned DB_W      = 16,
`endif
   parameter int unsigned WAIT_MAX  = 1023,
   parameter int unsigned WAIT_W    = 10
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             btn,
   input  logic [7:0]       sw,
   input  logic             op_sw,
   operand_loader_if.master proc,
   output logic [7:0]       result,
   output logic             err,
   output logic [2:0]       phase
);

   logic              press;
   logic [1:0]        op_sync;

   state_t            state_q, state_d;
   logic [7:0]        x_q, x_d;
   logic [7:0]        y_q, y_d;
   logic              op_q, op_d;
   logic              start_q, start_d;
   logic [7:0]        result_q, result_d;
   logic              err_q, err_d;
   logic [WAIT_W-1:0] wait_q, wait_d;

   operand_loader_btn_conditioner
`ifdef OPERAND_LOADER_DEBOUNCE_EN
   #(
      .DB_CYCLES (DB_CYCLES),
      .DB_W      (DB_W)
   )
`endif
   u_btn (
      .clk   (clk),
      .rst   (rst),
      .btn   (btn),
      .press (press)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) op_sync <= 2'b00;
      else     op_sync <= {op_sync[0], op_sw};
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= S_X;
         x_q      <= '0;
         y_q      <= '0;
         op_q     <= 1'b0;
         start_q  <= 1'b0;
         result_q <= '0;
         err_q    <= 1'b0;
         wait_q   <= '0;
      end else begin
         state_q  <= state_d;
         x_q      <= x_d;
         y_q      <= y_d;
         op_q     <= op_d;
         start_q  <= start_d;
         result_q <= result_d;
         err_q    <= err_d;
         wait_q   <= wait_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      x_d      = x_q;
      y_d      = y_q;
      op_d     = op_q;
      start_d  = 1'b0;
      result_d = result_q;
      err_d    = err_q;
      wait_d   = wait_q;

      case (state_q)
         S_X: begin
            if (press) begin
               x_d     = sw;
               state_d = S_Y;
            end
         end
         S_Y: begin
            if (press) begin
               y_d     = sw;
               state_d = S_GO;
            end
         end
         S_GO: begin
            if (press) begin
               op_d    = op_sync[1];
               start_d = 1'b1;
               wait_d  = '0;
               err_d   = 1'b0;
               state_d = S_RUN;
            end
         end
         S_RUN: begin
            // start_q marks the first RUN cycle, where a stale done must be ignored.
            if (!start_q && proc.done) begin
               result_d = proc.proc_result;
               state_d  = S_SHOW;
            end else if (wait_q == WAIT_W'(WAIT_MAX)) begin
               err_d    = 1'b1;
               result_d = RESULT_TIMEOUT;
               state_d  = S_SHOW;
            end else begin
               wait_d   = wait_q + 1'b1;
            end
         end
         S_SHOW: begin
            if (press) begin
               err_d   = 1'b0;
               state_d = S_X;
            end
         end
         default: state_d = S_X;
      endcase
   end

   assign proc.x     = x_q;
   assign proc.y     = y_q;
   assign proc.op    = op_q;
   assign proc.start = start_q;
   assign result     = result_q;
   assign err        = err_q;
   assign phase      = phase_of(state_q);

endmodule
